// File: rtl/ahb_pkg.sv
// Shared AHB definitions for the bus arbiter: transfer types, width constants
// and the one-hot to index helper.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam int HTRANS_W     = 2;
  localparam int MAX_MASTERS  = 16;
  localparam int MASTER_IDX_W = 4;

  // OR-ing the set positions is exact for a one-hot input and needs no priority chain.
  function automatic logic [MASTER_IDX_W-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
    logic [MASTER_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (oh[i]) idx = idx | MASTER_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational rotating-priority picker: first requester after start_i (with wrap),
// skipping masters in excl_i. A start of N-1 gives plain lowest-index priority.
module ahb_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  input  logic [N-1:0]  excl_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [N-1:0]  cand;
  logic [IW-1:0] pos;

  assign cand = req_i & ~excl_i;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    pos     = '0;
    for (int k = 1; k <= N; k++) begin
      pos = IW'((int'(start_i) + k) % N);
      if (!valid_o && cand[pos]) begin
        valid_o    = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter_n.sv
// N-master AHB arbiter: registered one-hot grant, round-robin or fixed priority,
// bounded tenure and idle parking. Locked tenures are compiled in with AHB_ARB_LOCK_EN.
module ahb_arbiter_n
  import ahb_pkg::*;
#(
  parameter int N_MASTERS  = 4,
  parameter bit RR_MODE    = 1'b1,
  parameter int DEF_MASTER = 0,
  parameter int MAX_HOLD   = 16
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic [N_MASTERS-1:0]         hbusreq_i,
  input  logic [N_MASTERS-1:0]         hlock_i,
  input  logic [HTRANS_W-1:0]          htrans_i,
  input  logic                         hready_i,
  output logic [N_MASTERS-1:0]         hgrant_o,
  output logic [$clog2(N_MASTERS)-1:0] hmaster_o,
  output logic                         hmastlock_o
);

  localparam int MW = $clog2(N_MASTERS);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [N_MASTERS-1:0] DEF_OH      = N_MASTERS'(1) << DEF_MASTER;
  localparam logic [MW-1:0]        DEF_IDX     = MW'(DEF_MASTER);
  localparam logic [MW-1:0]        FIXED_START = MW'(N_MASTERS - 1);
  localparam logic [HW-1:0]        HOLD_MAX    = HW'(MAX_HOLD);

  logic [N_MASTERS-1:0] grant_q, grant_d, pickGnt;
  logic [MW-1:0]        hmaster_q, ptr_q, ptr_d, owner, pickIdx, pickStart;
  logic [HW-1:0]        hold_q, hold_d;
  logic                 pickValid, ownerReq, holdDone, keepLock, beat;

  assign owner     = MW'(onehot_to_idx(MAX_MASTERS'(grant_q)));
  assign ownerReq  = |(hbusreq_i & grant_q);
  assign holdDone  = (MAX_HOLD != 0) && (hold_q == HOLD_MAX);
  assign beat      = htrans_t'(htrans_i) inside {NONSEQ, SEQ};
  assign pickStart = RR_MODE ? ptr_q : FIXED_START;

  // The current owner is always excluded: the picker is only consulted when it must yield.
  ahb_rr_pick #(
    .N  (N_MASTERS),
    .IW (MW)
  ) uPick (
    .req_i   (hbusreq_i),
    .start_i (pickStart),
    .excl_i  (grant_q),
    .gnt_o   (pickGnt),
    .idx_o   (pickIdx),
    .valid_o (pickValid)
  );

  always_comb begin
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (!keepLock && !(ownerReq && !holdDone)) begin
      if (pickValid) begin
        grant_d = pickGnt;
        ptr_d   = pickIdx;
      end else if (!ownerReq && (grant_q != DEF_OH)) begin
        grant_d = DEF_OH;
        ptr_d   = DEF_IDX;
      end
    end
    hold_d = hold_q;
    if (grant_d != grant_q) begin
      hold_d = '0;
    end else if (beat && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      grant_q   <= DEF_OH;
      hmaster_q <= DEF_IDX;
      ptr_q     <= DEF_IDX;
      hold_q    <= '0;
    end else if (hready_i) begin
      grant_q   <= grant_d;
      hmaster_q <= owner;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
    end
  end

`ifdef AHB_ARB_LOCK_EN
  logic locked_q, hmastlock_q;

  // A locked owner that keeps requesting with hlock set is never pre-empted.
  assign keepLock = locked_q && |(hbusreq_i & hlock_i & grant_q);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      locked_q    <= 1'b0;
      hmastlock_q <= 1'b0;
    end else if (hready_i) begin
      locked_q    <= |(hbusreq_i & hlock_i & grant_d);
      hmastlock_q <= locked_q;
    end
  end

  assign hmastlock_o = hmastlock_q;
`else
  logic unusedLock;

  assign unusedLock  = ^hlock_i;
  assign keepLock    = 1'b0;
  assign hmastlock_o = 1'b0;
`endif

  assign hgrant_o  = grant_q;
  assign hmaster_o = hmaster_q;

endmodule

// File: tb/tb_ahb_arbiter_n.sv
// Self-checking bench for ahb_arbiter_n: a round-robin and a fixed-priority instance
// share stimulus and are compared every cycle against an in-bench arbitration model.
module tb_ahb_arbiter_n;
  import ahb_pkg::*;

  localparam int N    = 4;
  localparam int DEF  = 0;
  localparam int MAXH = 4;
  localparam int RR_SEQ [5] = '{1, 2, 3, 0, 1};
`ifdef AHB_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] hbusreq = '0;
  logic [3:0] hlock = '0;
  logic [1:0] htrans = IDLE;
  logic       hready = 1'b1;
  logic [3:0] gntRr, gntFx;
  logic [1:0] mstRr, mstFx;
  logic       lockRr, lockFx;

  int assertCount = 0;
  int failCount   = 0;
  bit checkEn     = 1'b0;

  int mOwner [2];
  int mPtr [2];
  int mHold [2];
  int mMaster [2];
  bit mLocked [2];
  bit mMastLock [2];

  always #5 clk = ~clk;

  ahb_arbiter_n #(.N_MASTERS(N), .RR_MODE(1'b1), .DEF_MASTER(DEF), .MAX_HOLD(MAXH)) dutRr (
    .clk_i(clk), .rstn_i(rstn), .hbusreq_i(hbusreq), .hlock_i(hlock), .htrans_i(htrans),
    .hready_i(hready), .hgrant_o(gntRr), .hmaster_o(mstRr), .hmastlock_o(lockRr)
  );

  ahb_arbiter_n #(.N_MASTERS(N), .RR_MODE(1'b0), .DEF_MASTER(DEF), .MAX_HOLD(MAXH)) dutFx (
    .clk_i(clk), .rstn_i(rstn), .hbusreq_i(hbusreq), .hlock_i(hlock), .htrans_i(htrans),
    .hready_i(hready), .hgrant_o(gntFx), .hmaster_o(mstFx), .hmastlock_o(lockFx)
  );

  function automatic logic [3:0] expGnt(input int m);
    logic [3:0] g;
    g    = '0;
    g[m] = 1'b1;
    return g;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic [3:0] lck,
                               input logic [1:0] trans, input logic rdy);
    @(negedge clk);
    #1;
    hbusreq = req;
    hlock   = lck;
    htrans  = trans;
    hready  = rdy;
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    @(negedge clk);
    #1;
    rstn    = 1'b0;
    hbusreq = '0;
    hlock   = '0;
    htrans  = IDLE;
    hready  = 1'b1;
    @(negedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // Model: index 0 is round-robin, index 1 is fixed priority (lowest index first).
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int d = 0; d < 2; d++) begin
        mOwner[d]    <= DEF;
        mPtr[d]      <= DEF;
        mHold[d]     <= 0;
        mMaster[d]   <= DEF;
        mLocked[d]   <= 1'b0;
        mMastLock[d] <= 1'b0;
      end
    end else if (hready) begin
      for (int d = 0; d < 2; d++) begin
        int cur, win, cand, first, idx;
        bit ownerReq, lockKeep;
        cur      = mOwner[d];
        ownerReq = hbusreq[cur];
        first    = (d == 0) ? mPtr[d] + 1 : 0;
        cand     = -1;
        for (int k = 0; k < N; k++) begin
          idx = (first + k) % N;
          if (cand < 0 && idx != cur && hbusreq[idx]) cand = idx;
        end
        lockKeep = LOCK_EN && mLocked[d] && ownerReq && hlock[cur];
        if (lockKeep || (ownerReq && mHold[d] < MAXH)) win = cur;
        else if (cand >= 0) win = cand;
        else if (ownerReq) win = cur;
        else win = DEF;
        mOwner[d] <= win;
        if (win != cur) begin
          mPtr[d]  <= win;
          mHold[d] <= 0;
        end else if ((htrans == NONSEQ || htrans == SEQ) && mHold[d] < MAXH) begin
          mHold[d] <= mHold[d] + 1;
        end
        mMaster[d]   <= cur;
        mMastLock[d] <= mLocked[d];
        mLocked[d]   <= LOCK_EN && hbusreq[win] && hlock[win];
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model rr hgrant", gntRr, expGnt(mOwner[0]));
      checkOutput("model rr hmaster", mstRr, mMaster[0]);
      checkOutput("model rr hmastlock", lockRr, mMastLock[0]);
      checkOutput("model fx hgrant", gntFx, expGnt(mOwner[1]));
      checkOutput("model fx hmaster", mstFx, mMaster[1]);
      checkOutput("model fx hmastlock", lockFx, mMastLock[1]);
    end
  end

  initial begin
    int prevOwner;
    repeat (2) @(negedge clk);
    checkEn = 1'b1;
    checkOutput("reset hgrant", gntRr, 4'b0001);
    checkOutput("reset hmaster", mstRr, 0);
    checkOutput("reset hmastlock", lockRr, 0);
    checkOutput("reset fx hgrant", gntFx, 4'b0001);
    @(negedge clk);
    #1 rstn = 1'b1;
    applyStimulus(4'b0000, 4'b0000, IDLE, 1'b1);
    applyStimulus(4'b0000, 4'b0000, IDLE, 1'b1);
    checkOutput("park hgrant", gntRr, 4'b0001);
    checkOutput("park hmaster", mstRr, 0);

    // Each owner drops its request after one beat, so the grant walks round the ring.
    prevOwner = 0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b1111 & ~(4'b0001 << prevOwner), 4'b0000, NONSEQ, 1'b1);
      checkOutput("rr rotate hgrant", gntRr, 4'b0001 << RR_SEQ[k]);
      checkOutput("rr rotate hmaster", mstRr, prevOwner);
      prevOwner = RR_SEQ[k];
    end

    doReset();
    applyStimulus(4'b1010, 4'b0000, NONSEQ, 1'b1);
    checkOutput("fixed lowest hgrant", gntFx, 4'b0010);
    applyStimulus(4'b1000, 4'b0000, NONSEQ, 1'b1);
    checkOutput("fixed drop hgrant", gntFx, 4'b1000);

    doReset();
    applyStimulus(4'b0100, 4'b0000, IDLE, 1'b1);
    checkOutput("tenure start hgrant", gntRr, 4'b0100);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(4'b0110, 4'b0000, SEQ, 1'b1);
      checkOutput("tenure hgrant", gntRr, (k <= 4) ? 4'b0100 : 4'b0010);
    end
    checkOutput("tenure fx hgrant", gntFx, 4'b0010);

    doReset();
    applyStimulus(4'b0100, 4'b0000, IDLE, 1'b1);
    for (int k = 0; k < 6; k++) applyStimulus(4'b0100, 4'b0000, SEQ, 1'b1);
    checkOutput("sole keep hgrant", gntRr, 4'b0100);
    applyStimulus(4'b0110, 4'b0000, SEQ, 1'b1);
    checkOutput("saturated switch hgrant", gntRr, 4'b0010);

    doReset();
    applyStimulus(4'b0010, 4'b0000, IDLE, 1'b1);
    applyStimulus(4'b0010, 4'b0000, IDLE, 1'b1);
    checkOutput("pre-freeze hmaster", mstRr, 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b1000, 4'b0000, IDLE, 1'b0);
      checkOutput("freeze hgrant", gntRr, 4'b0010);
      checkOutput("freeze hmaster", mstRr, 1);
    end
    applyStimulus(4'b1000, 4'b0000, IDLE, 1'b1);
    checkOutput("unfreeze hgrant", gntRr, 4'b1000);
    checkOutput("unfreeze hmaster", mstRr, 1);
    applyStimulus(4'b1000, 4'b0000, NONSEQ, 1'b1);
    checkOutput("unfreeze lag hmaster", mstRr, 3);

    #1 rstn = 1'b0;
    #1;
    checkOutput("async reset hgrant", gntRr, 4'b0001);
    checkOutput("async reset hmaster", mstRr, 0);
    checkOutput("async reset hmastlock", lockRr, 0);
    @(negedge clk);
    #1 rstn = 1'b1;

    applyStimulus(4'b0010, 4'b0010, NONSEQ, 1'b1);
    checkOutput("lock start hgrant", gntRr, 4'b0010);
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(4'b1010, 4'b0010, SEQ, 1'b1);
`ifdef AHB_ARB_LOCK_EN
      checkOutput("locked hgrant", gntRr, 4'b0010);
      checkOutput("locked hmastlock", lockRr, 1);
`else
      if (k == 4) checkOutput("unlocked hold hgrant", gntRr, 4'b0010);
      if (k == 5) checkOutput("unlocked preempt hgrant", gntRr, 4'b1000);
`endif
    end
    applyStimulus(4'b1010, 4'b0000, SEQ, 1'b1);
`ifdef AHB_ARB_LOCK_EN
    checkOutput("unlock switch hgrant", gntRr, 4'b1000);
`endif
    applyStimulus(4'b0000, 4'b0000, IDLE, 1'b1);
    applyStimulus(4'b0000, 4'b0000, IDLE, 1'b1);

    @(negedge clk);
    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
